// File: rtl/cmos_inverter_cell_if.sv
// Signal bundle for one inverter stage: gate drives and clear in, resolved
// output, node flags and event counters out.
//
// Handshake: there is no valid/ready pair. The driver presents gate_p,
// gate_n and clr before each rising clk1 edge, and every edge consumes them.
// All outputs are registered in the cell and hold between edges.
interface cmos_inverter_cell_if #(
  parameter int CNT_W = 16
);
  logic             gate_p;
  logic             gate_n;
  logic             clr;
  logic             out5;
  logic             out_z;
  logic             out_x;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] fall_cnt;
  logic [CNT_W-1:0] cont_cnt;

  modport master (
    output gate_p, gate_n, clr,
    input  out5, out_z, out_x, rise_cnt, fall_cnt, cont_cnt
  );

  modport slave (
    input  gate_p, gate_n, clr,
    output out5, out_z, out_x, rise_cnt, fall_cnt, cont_cnt
  );
endinterface

// File: rtl/cmos_inverter_cell.sv
// Clocked behavioural model of one static CMOS inverter stage.
// The pull-up conducts when gate_p is 0 and the pull-down when gate_n is 1.
// The resolved node is registered and can optionally be delayed. The stage
// also counts rise, fall and contention events seen at the reported output.
// Optional feature macro: INV_DELAY_EN. When it is defined, DELAY extra
// register stages sit between resolution and the reported outputs.
module cmos_inverter_cell #(
  parameter int CNT_W = 16,
  parameter int DELAY = 2
) (
  input logic                clk1,
  input logic                rst,
  cmos_inverter_cell_if.slave bus
);

  // Elaboration-time legality checks on the parameters
  if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
    $error("cmos_inverter_cell: CNT_W out of range 4..32");
  end
  if (DELAY < 1 || DELAY > 8) begin : g_bad_delay
    $error("cmos_inverter_cell: DELAY out of range 1..8");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic pu;
  logic pd;
  assign pu = ~bus.gate_p;
  assign pd = bus.gate_n;

  logic out5_q, out5_d;
  logic out_z_q, out_z_d;
  logic out_x_q, out_x_d;

  // Resolve the node: a single conducting switch drives it; when neither or
  // both conduct, the previous level is retained and the matching flag is set
  always_comb begin
    out5_d  = out5_q;
    out_z_d = 1'b0;
    out_x_d = 1'b0;
    case ({pu, pd})
      2'b10:   out5_d  = 1'b1;
      2'b01:   out5_d  = 1'b0;
      2'b00:   out_z_d = 1'b1;
      default: out_x_d = 1'b1;
    endcase
  end

  // Resolution register
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      out5_q  <= 1'b0;
      out_z_q <= 1'b0;
      out_x_q <= 1'b0;
    end else begin
      out5_q  <= out5_d;
      out_z_q <= out_z_d;
      out_x_q <= out_x_d;
    end
  end

  // Reported stage: {out5, out_z, out_x} as seen at the block outputs
  logic [2:0] rep;

`ifdef INV_DELAY_EN
  logic [DELAY-1:0][2:0] pipe_q, pipe_d;

  // Shift the resolved triple through DELAY propagation-delay stages
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {out5_q, out_z_q, out_x_q};
    for (int i = 1; i < DELAY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Delay-line register
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign rep = pipe_q[DELAY-1];
`else
  assign rep = {out5_q, out_z_q, out_x_q};
`endif

  logic             prev_out5_q, prev_out5_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
  logic [CNT_W-1:0] cont_cnt_q, cont_cnt_d;

  // Event counters: compare the reported out5 with the value it held one
  // cycle earlier; saturate at all-ones; clr wins over any increment
  always_comb begin
    prev_out5_d = rep[2];
    rise_cnt_d  = rise_cnt_q;
    fall_cnt_d  = fall_cnt_q;
    cont_cnt_d  = cont_cnt_q;
    if (bus.clr) begin
      rise_cnt_d = '0;
      fall_cnt_d = '0;
      cont_cnt_d = '0;
    end else begin
      if (rep[2] && !prev_out5_q && rise_cnt_q != CNT_MAX) begin
        rise_cnt_d = rise_cnt_q + 1'b1;
      end
      if (!rep[2] && prev_out5_q && fall_cnt_q != CNT_MAX) begin
        fall_cnt_d = fall_cnt_q + 1'b1;
      end
      if (rep[0] && cont_cnt_q != CNT_MAX) begin
        cont_cnt_d = cont_cnt_q + 1'b1;
      end
    end
  end

  // Counter and edge-history registers
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      prev_out5_q <= 1'b0;
      rise_cnt_q  <= '0;
      fall_cnt_q  <= '0;
      cont_cnt_q  <= '0;
    end else begin
      prev_out5_q <= prev_out5_d;
      rise_cnt_q  <= rise_cnt_d;
      fall_cnt_q  <= fall_cnt_d;
      cont_cnt_q  <= cont_cnt_d;
    end
  end

  assign bus.out5     = rep[2];
  assign bus.out_z    = rep[1];
  assign bus.out_x    = rep[0];
  assign bus.rise_cnt = rise_cnt_q;
  assign bus.fall_cnt = fall_cnt_q;
  assign bus.cont_cnt = cont_cnt_q;

endmodule

// File: tb/tb_cmos_inverter_cell.sv
// Bench for cmos_inverter_cell: a 16-bit-counter instance and a 4-bit-counter
// instance are driven with identical gate streams. A cycle-level model built
// from the switch rules predicts outputs and counter values for both.
module tb_cmos_inverter_cell;

  localparam int DELAY_P = 2;
`ifdef INV_DELAY_EN
  localparam int D = DELAY_P;
`else
  localparam int D = 0;
`endif
  localparam int LAT = 1 + D;

  // ---------------- clock / reset ----------------
  logic clk1;
  logic rst;

  initial begin
    clk1 = 1'b0;
    forever #5000 clk1 = ~clk1;
  end

  cmos_inverter_cell_if #(.CNT_W(16)) if16 ();
  cmos_inverter_cell_if #(.CNT_W(4))  if4 ();

  cmos_inverter_cell #(.CNT_W(16), .DELAY(DELAY_P)) dut16 (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (if16)
  );

  cmos_inverter_cell #(.CNT_W(4), .DELAY(DELAY_P)) dut4 (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (if4)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Node level after each edge, a FIFO of {out5,z,x} triples standing for the
  // propagation delay, and unbounded event tallies since the last clear.
  logic       m_node;
  logic [2:0] m_fifo[$];
  logic [2:0] m_cur;
  logic [2:0] m_prev;
  int         raw_rise, raw_fall, raw_cont;

  function automatic logic [31:0] sat(input int raw, input int max);
    return (raw > max) ? max : raw;
  endfunction

  task automatic model_reset();
    m_node = 1'b0;
    m_fifo.delete();
    for (int i = 0; i < D; i++) m_fifo.push_back(3'b000);
    m_cur    = 3'b000;
    m_prev   = 3'b000;
    raw_rise = 0;
    raw_fall = 0;
    raw_cont = 0;
  endtask

  task automatic model_edge(input logic gp, input logic gn, input logic c);
    logic up, dn;
    up = !gp;
    dn = gn;
    // events are judged on what is visible at the outputs just before the edge
    if (c) begin
      raw_rise = 0;
      raw_fall = 0;
      raw_cont = 0;
    end else begin
      if (m_cur[2] && !m_prev[2]) raw_rise++;
      if (!m_cur[2] && m_prev[2]) raw_fall++;
      if (m_cur[0]) raw_cont++;
    end
    if (up && !dn) m_node = 1'b1;
    else if (dn && !up) m_node = 1'b0;
    m_fifo.push_back({m_node, !up && !dn, up && dn});
    m_prev = m_cur;
    m_cur  = m_fifo.pop_front();
  endtask

  task automatic compare_all();
    check("d16.out5", {31'd0, if16.out5}, {31'd0, m_cur[2]});
    check("d16.out_z", {31'd0, if16.out_z}, {31'd0, m_cur[1]});
    check("d16.out_x", {31'd0, if16.out_x}, {31'd0, m_cur[0]});
    check("d16.rise", {16'd0, if16.rise_cnt}, sat(raw_rise, 65535));
    check("d16.fall", {16'd0, if16.fall_cnt}, sat(raw_fall, 65535));
    check("d16.cont", {16'd0, if16.cont_cnt}, sat(raw_cont, 65535));
    check("d4.out5", {31'd0, if4.out5}, {31'd0, m_cur[2]});
    check("d4.out_z", {31'd0, if4.out_z}, {31'd0, m_cur[1]});
    check("d4.out_x", {31'd0, if4.out_x}, {31'd0, m_cur[0]});
    check("d4.rise", {28'd0, if4.rise_cnt}, sat(raw_rise, 15));
    check("d4.fall", {28'd0, if4.fall_cnt}, sat(raw_fall, 15));
    check("d4.cont", {28'd0, if4.cont_cnt}, sat(raw_cont, 15));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic gp, input logic gn, input logic c);
    if16.gate_p = gp;
    if16.gate_n = gn;
    if16.clr    = c;
    if4.gate_p  = gp;
    if4.gate_n  = gn;
    if4.clr     = c;
  endtask

  // One clock: drive at the falling edge, check 1 time unit after the rise
  task automatic step(input logic gp, input logic gn, input logic c);
    @(negedge clk1);
    drive(gp, gn, c);
    @(posedge clk1);
    #1;
    model_edge(gp, gn, c);
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out5"}, {31'd0, if16.out5 | if4.out5}, 32'd0);
    check({tag, ".flags"}, {30'd0, if16.out_z | if4.out_z, if16.out_x | if4.out_x}, 32'd0);
    check({tag, ".cnt16"}, {16'd0, if16.rise_cnt | if16.fall_cnt | if16.cont_cnt}, 32'd0);
    check({tag, ".cnt4"}, {28'd0, if4.rise_cnt | if4.fall_cnt | if4.cont_cnt}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk1);
    check_all_zero("reset");
    rst = 1'b0;

    // Inverter mode: tied gates toggled from 0 for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(logic'(i % 2), logic'(i % 2), 1'b0);
    end
    for (int i = 0; i <= D; i++) step(1'b1, 1'b0, 1'b0);
    check("inv.rise", {16'd0, if16.rise_cnt}, 32'd5);
    check("inv.fall", {16'd0, if16.fall_cnt}, 32'd5);
    check("inv.cont", {16'd0, if16.cont_cnt}, 32'd0);

    // Floating node after driving 1: level retained, no fall
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3 + D + 1; i++) step(1'b1, 1'b0, 1'b0);
    check("float.out5", {31'd0, if16.out5}, 32'd1);
    check("float.fall", {16'd0, if16.fall_cnt}, 32'd5);

    // Contention for 4 cycles after the node is low
    for (int i = 0; i < D + 2; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= D; i++) step(1'b1, 1'b0, 1'b0);
    check("cont.out5", {31'd0, if16.out5}, 32'd0);
    check("cont.cnt16", {16'd0, if16.cont_cnt}, 32'd4);
    check("cont.cnt4", {28'd0, if4.cont_cnt}, 32'd4);

    // Saturation: 20 rise/fall pairs from a cleared state
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i <= D; i++) step(1'b1, 1'b0, 1'b0);
    check("sat.rise4", {28'd0, if4.rise_cnt}, 32'd15);
    check("sat.fall4", {28'd0, if4.fall_cnt}, 32'd15);
    check("sat.rise16", {16'd0, if16.rise_cnt}, 32'd20);

    // Clear on the same edge that would count a rise
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("clr.rise4", {28'd0, if4.rise_cnt}, 32'd0);
    check("clr.rise16", {16'd0, if16.rise_cnt}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("clr.after", {16'd0, if16.rise_cnt}, 32'd0);

    // Output latency of a single step to pull-down
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (if16.out5 == 1'b0) begin
        n = i;
        break;
      end
    end
    check("lat.out5", n, LAT);
    check("lat.fall_pre", {16'd0, if16.fall_cnt}, 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("lat.fall", {16'd0, if16.fall_cnt}, 32'd1);

    // Randomized gate pairs with occasional clears
    for (int i = 0; i < 300; i++) begin
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between edges, mid-operation
    @(negedge clk1);
    #1000;
    rst = 1'b1;
    #10;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk1);
    rst = 1'b0;

    // Short random run after reset release
    for (int i = 0; i < 60; i++) begin
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmos_inverter_cell.md
# cmos_inverter_cell

Clocked behavioural model of a single static CMOS inverter stage: one pull-up (pmos) and one pull-down (nmos) switch, output resolution, and edge/contention statistics. It sits in the switch-level characterization path. Each gate pair is sampled on `clk1`. The block produces a registered logic output plus flags and counters for rise, fall, floating-node and contention events. With `gate_p` and `gate_n` tied together, it is a plain inverter.

## Interface
Parameters:
- `CNT_W`, default 16: width of every event counter (legal 4..32).
- `DELAY`, default 2: extra output pipeline stages; used only when `INV_DELAY_EN` is defined (legal 1..8).

Ports:
- `clk1`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `gate_p`  in  1  pmos gate; pull-up conducts when 0.
- `gate_n`  in  1  nmos gate; pull-down conducts when 1.
- `clr`  in  1  synchronous clear of all counters.
- `out5`  out  1  resolved, registered logic output.
- `out_z`  out  1  node floating (neither switch on) in the reported cycle.
- `out_x`  out  1  contention (both switches on) in the reported cycle.
- `rise_cnt`  out  CNT_W  count of `out5` 0→1 transitions.
- `fall_cnt`  out  CNT_W  count of `out5` 1→0 transitions.
- `cont_cnt`  out  CNT_W  count of cycles with `out_x`=1.

## Operation
- The block is clocked by a single clock, `clk1`; reset `rst` is asynchronous and active-high.
- Conduction: `pu` = ~`gate_p`, `pd` = `gate_n`.
- Resolution on each `clk1` rising edge:
  - `pu` only: `out5`←1, `out_z`←0, `out_x`←0.
  - `pd` only: `out5`←0, `out_z`←0, `out_x`←0.
  - Neither on: `out5` holds its previous value (charge retention), `out_z`←1, `out_x`←0.
  - Both on: `out5` holds its previous value, `out_x`←1, `out_z`←0.
- Edge detection compares the new `out5` with the previous `out5` at the reported (pipeline-output) stage.
  - 0→1 increments `rise_cnt`.
  - 1→0 increments `fall_cnt`.
  - Hold states cause no edge.
- `cont_cnt` increments on every reported cycle with `out_x`=1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `clr`=1 forces all counters to 0 on that edge. It overrides any increment in the same cycle and does not affect `out5`, `out_z` or `out_x`.
- Reset (`rst`=1), effective immediately and asynchronously, including mid-operation:
  - `out5`, `out_z`, `out_x` = 0.
  - All counters = 0.
  - All pipeline stages = 0.
- First edge after reset release: a resolved 1 counts as a rise, because the reset `out5` is 0.

## Timing
- Without `INV_DELAY_EN`: 1-cycle latency from gate inputs to `out5`/`out_z`/`out_x`.
- Counters reflect an event 1 cycle after the flag appears, i.e. 2 cycles after the inputs.
- With `INV_DELAY_EN`: outputs delayed 1+`DELAY` cycles. Counters observe the pipeline output, so counter latency is 2+`DELAY`.
- No combinational path from any input to any output.
- Nominal `clk1` period: 10000 time units (half-period 5000).

## Configuration
- `INV_DELAY_EN` defined: a `DELAY`-stage shift register is inserted after resolution, carrying `out5`, `out_z` and `out_x` together. It models propagation delay, and the stages reset to 0.
- `INV_DELAY_EN` undefined: no extra stages, and `DELAY` is ignored.

## Test plan
- Reset: assert `rst` asynchronously between edges.
  - → `out5`=0, flags 0, all counters 0 immediately.
- Inverter mode (`gate_p`=`gate_n`, toggled every cycle for 10 cycles starting at 0, no delay).
  - → `out5` is the inverse of the input, one cycle late.
  - → `rise_cnt`=5, `fall_cnt`=5, `cont_cnt`=0.
- Floating node: drive 1 (`gate_p`=0, `gate_n`=0), then `gate_p`=1, `gate_n`=0 for 3 cycles.
  - → `out5` stays 1, `out_z`=1 for 3 cycles, no fall counted.
- Contention: `gate_p`=0, `gate_n`=1 for 4 cycles after `out5`=0.
  - → `out_x`=1 for 4 cycles, `out5` stays 0, `cont_cnt`=4.
- Saturation and clear with `CNT_W`=4: 20 rise/fall pairs.
  - → `rise_cnt`=`fall_cnt`=15.
  - Then pulse `clr` coincident with a rise → `rise_cnt`=0.
- `INV_DELAY_EN` with `DELAY`=2: single input step to pull-down.
  - → `out5` falls exactly 3 cycles after the input.
  - → `fall_cnt`=1 one cycle after that.
